// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus widths,
// register offsets inside the address window, TX FSM state encoding and the
// STATUS register layout.
package uart_tx_mmio_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = 3;

  // Register offsets relative to BASE_ADDR
  localparam logic [ADDR_W-1:0] DATA_OFS   = 24'd0;
  localparam logic [ADDR_W-1:0] STATUS_OFS = 24'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // STATUS word as seen by a CPU load
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [3:0]  rsvd_lo;
    logic        overflow;
    logic        full;
    logic        empty;
    logic        busy;
  } status_t;

  // Serial line level driven while the FSM sits in a given state
  function automatic logic line_level(input tx_state_e st, input logic data_bit);
    case (st)
      ST_START: return 1'b0;
      ST_DATA:  return data_bit;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous fall-through FIFO: head entry is always visible on o_rdata.
// Ports: i_clk/i_rstb (sync active-low reset), i_push/i_wdata, i_pop,
//        o_rdata (head), o_full, o_empty, o_count (0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_mmio_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rstb,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  // When full, the popped slot is the one being written, so push+pop is safe
  assign do_push = i_push & (~o_full | i_pop);
  assign do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy update; pointers wrap modulo DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; only the pointers define validity
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
// Ports: i_clk, i_rstb (sync active-low), i_clk_en (global enable),
//        i_addr/i_wr/i_rd/i_wdata (CPU bus), o_sel (address in window),
//        o_rdata (combinational load data), o_txd (serial line, idle high),
//        o_irq (FIFO empty and shifter idle).
// DATA at BASE_ADDR accepts byte stores; STATUS at BASE_ADDR+1 reads
// {16'b0, count, 4'b0, overflow, full, empty, busy}.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR  = 24'hFFFFF0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] BAUD_DIV   = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_rstb,
  input  logic        i_clk_en,
  input  logic [23:0] i_addr,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [31:0] i_wdata,
  output logic        o_sel,
  output logic [31:0] o_rdata,
  output logic        o_txd,
  output logic        o_irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BYTE_W-1:0]  sh_q, sh_d;
  logic               txd_q, txd_d;
  logic               ovf_q, ovf_d;

  logic               sel_data, sel_status;
  logic               push_req, status_rd, ovf_set;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic               baud_last;
  status_t            status_w;
  logic [23:0]        unused_wdata;

  assign unused_wdata = i_wdata[31:8];

  // Address decode
  assign sel_data   = (i_addr == BASE_ADDR + DATA_OFS);
  assign sel_status = (i_addr == BASE_ADDR + STATUS_OFS);
  assign o_sel      = sel_data | sel_status;

  // Bus side effects; a full-FIFO push survives only if the FSM pops this cycle
  assign push_req  = i_clk_en & i_wr & sel_data;
  assign status_rd = i_clk_en & i_rd & sel_status;
  assign fifo_push = push_req & (~fifo_full | fifo_pop);
  assign ovf_set   = push_req & fifo_full & ~fifo_pop;

  uart_tx_mmio_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstb  (i_rstb),
    .i_push  (fifo_push),
    .i_wdata (i_wdata[7:0]),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // STATUS word and load data mux
  always_comb begin
    status_w          = '0;
    status_w.count    = 8'(fifo_count);
    status_w.overflow = ovf_q;
    status_w.full     = fifo_full;
    status_w.empty    = fifo_empty;
    status_w.busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    o_rdata = '0;
    if (i_rd && sel_status) o_rdata = status_w;
  end

  assign o_irq = fifo_empty & (state_q == ST_IDLE);
  assign o_txd = txd_q;

  // Sticky overflow: a new overflow in the clearing cycle wins
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)        ovf_d = 1'b1;
    else if (status_rd) ovf_d = 1'b0;
  end

  assign baud_last = (baud_q == BAUD_DIV - 16'd1);

  // TX FSM; the line level is registered from the next state so a frame
  // starts on the cycle the head byte is popped
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    fifo_pop = 1'b0;
    txd_d    = txd_q;
    if (i_clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = fifo_rdata;
            baud_d   = '0;
            state_d  = ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            baud_d = baud_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_d = '0;
            sh_d   = {1'b0, sh_q[7:1]};
            if (bit_q == 3'd7) state_d = ST_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            baud_d = baud_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_d = '0;
            // Back-to-back frames: next start bit follows the stop bit directly
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              sh_d     = fifo_rdata;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            baud_d = baud_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      txd_d = line_level(state_d, sh_d[0]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
